// File: rtl/symbol_mapper_if.sv
// Byte/symbol bus between the packer side and the symbol mapper.
// The master drives bytes, mode and symbol strobes; the slave returns I/Q and status flags.
interface symbol_mapper_if;
  logic              start;
  logic [1:0]        mode;
  logic [7:0]        data_in;
  logic              data_en;
  logic              sym_tick;
  logic signed [3:0] i_out;
  logic signed [3:0] q_out;
  logic              sym_valid;
  logic              overflow;
  logic              underrun;
  logic              fifo_empty;

  modport master (
    output start, mode, data_in, data_en, sym_tick,
    input  i_out, q_out, sym_valid, overflow, underrun, fifo_empty
  );

  modport slave (
    input  start, mode, data_in, data_en, sym_tick,
    output i_out, q_out, sym_valid, overflow, underrun, fifo_empty
  );
endinterface

// File: rtl/symbol_mapper.sv
// Buffers packed bytes in a small FIFO and emits one Gray-mapped signed I/Q
// symbol (BPSK/QPSK/16QAM) per sym_tick, flagging overflow and underrun.
module symbol_mapper #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  symbol_mapper_if.slave  bus
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_q, state_d;
  logic [7:0]        mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic [7:0]        shift_q, shift_d;
  logic [3:0]        bits_left_q, bits_left_d;
  logic [1:0]        mode_q, mode_d;
  logic signed [3:0] i_q, i_d;
  logic signed [3:0] q_q, q_d;
  logic              sym_valid_q, sym_valid_d;
  logic              overflow_q, overflow_d;
  logic              underrun_q, underrun_d;

  logic              full, empty, tick_send, byte_done, push, pop;
  logic [3:0]        k;

  function automatic logic signed [3:0] map_bit(input logic b);
    return b ? -4'sd3 : 4'sd3;
  endfunction

  function automatic logic signed [3:0] map_gray(input logic [1:0] g);
    case (g)
      2'b00:   return -4'sd3;
      2'b01:   return -4'sd1;
      2'b11:   return 4'sd1;
      default: return 4'sd3;
    endcase
  endfunction

  function automatic logic [3:0] bits_per_sym(input logic [1:0] m);
    case (m)
      2'b00:   return 4'd1;
      2'b10:   return 4'd4;
      default: return 4'd2;
    endcase
  endfunction

  always_comb begin
    full      = (count_q == (AW+1)'(DEPTH));
    empty     = (count_q == '0);
    k         = bits_per_sym(mode_q);
    tick_send = bus.start && bus.sym_tick && (state_q == SEND);
    // Mode is fixed per byte, so bits_left is always a multiple of k.
    byte_done = tick_send && (bits_left_q == k);
    pop       = bus.start && !empty && ((state_q == IDLE) || byte_done);
    push      = bus.start && bus.data_en && (!full || pop);
  end

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    shift_d     = shift_q;
    bits_left_d = bits_left_q;
    mode_d      = mode_q;
    i_d         = i_q;
    q_d         = q_q;
    sym_valid_d = 1'b0;
    overflow_d  = overflow_q;
    underrun_d  = 1'b0;

    if (!bus.start) begin
      state_d     = IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      shift_d     = '0;
      bits_left_d = '0;
      mode_d      = '0;
      i_d         = '0;
      q_d         = '0;
      overflow_d  = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
      if (bus.data_en && full && !pop) overflow_d = 1'b1;

      // A tick during IDLE (including the load cycle) has no bits to send.
      if (bus.sym_tick && (state_q == IDLE)) begin
        underrun_d = 1'b1;
        i_d        = '0;
        q_d        = '0;
      end

      if (tick_send) begin
        sym_valid_d = 1'b1;
        case (mode_q)
          2'b00: begin
            i_d = map_bit(shift_q[7]);
            q_d = '0;
          end
          2'b10: begin
            i_d = map_gray(shift_q[7:6]);
            q_d = map_gray(shift_q[5:4]);
          end
          default: begin
            i_d = map_bit(shift_q[7]);
            q_d = map_bit(shift_q[6]);
          end
        endcase
        shift_d     = shift_q << k;
        bits_left_d = bits_left_q - k;
      end

      if (pop) begin
        shift_d     = mem[rd_ptr_q];
        mode_d      = (bus.mode == 2'b11) ? 2'b01 : bus.mode;
        bits_left_d = 4'd8;
        state_d     = SEND;
      end else if (byte_done) begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= bus.data_in;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      shift_q     <= '0;
      bits_left_q <= '0;
      mode_q      <= '0;
      i_q         <= '0;
      q_q         <= '0;
      sym_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      shift_q     <= shift_d;
      bits_left_q <= bits_left_d;
      mode_q      <= mode_d;
      i_q         <= i_d;
      q_q         <= q_d;
      sym_valid_q <= sym_valid_d;
      overflow_q  <= overflow_d;
      underrun_q  <= underrun_d;
    end
  end

  assign bus.i_out      = i_q;
  assign bus.q_out      = q_q;
  assign bus.sym_valid  = sym_valid_q;
  assign bus.overflow   = overflow_q;
  assign bus.underrun   = underrun_q;
  assign bus.fifo_empty = empty;

endmodule

// File: tb/tb_symbol_mapper.sv
// Directed bench for symbol_mapper: table of single-byte vectors plus
// hand-written overflow, abort, mode-switch and async-reset sequences.
module tb_symbol_mapper;

  logic clk;
  logic reset_n;
  int   n_chk;
  int   n_fail;

  symbol_mapper_if bus();

  symbol_mapper #(.DEPTH(8), .AW(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  mode;
    logic [7:0]  data;
    int          nsym;
    logic [31:0] ei;   // expected I per symbol, one nibble each, first symbol in [31:28]
    logic [31:0] eq;
  } vec_t;

  vec_t vec [5];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic write_byte(input logic [7:0] b);
    bus.data_in = b;
    bus.data_en = 1'b1;
    cyc();
    bus.data_en = 1'b0;
  endtask

  task automatic tick_chk(input string name, input int ei, input int eq);
    bus.sym_tick = 1'b1;
    cyc();
    bus.sym_tick = 1'b0;
    chk({name, ".valid"}, int'(bus.sym_valid), 1);
    chk({name, ".i"}, int'(bus.i_out), ei);
    chk({name, ".q"}, int'(bus.q_out), eq);
  endtask

  task automatic tick_underrun(input string name);
    bus.sym_tick = 1'b1;
    cyc();
    bus.sym_tick = 1'b0;
    chk({name, ".underrun"}, int'(bus.underrun), 1);
    chk({name, ".valid"}, int'(bus.sym_valid), 0);
    chk({name, ".i"}, int'(bus.i_out), 0);
    chk({name, ".q"}, int'(bus.q_out), 0);
  endtask

  function automatic int gray_ref(input logic [1:0] g);
    case (g)
      2'b00:   return -3;
      2'b01:   return -1;
      2'b11:   return 1;
      default: return 3;
    endcase
  endfunction

  initial begin
    logic [3:0] ni, nq;
    logic [7:0] nb;
    n_chk  = 0;
    n_fail = 0;

    vec[0] = '{2'b01, 8'hB4, 4, 32'hDD33_0000, 32'h3DD3_0000};
    vec[1] = '{2'b10, 8'h5A, 2, 32'hF300_0000, 32'hF300_0000};
    vec[2] = '{2'b10, 8'hF0, 2, 32'h1D00_0000, 32'h1D00_0000};
    vec[3] = '{2'b00, 8'h81, 8, 32'hD333_333D, 32'h0000_0000};
    vec[4] = '{2'b11, 8'h4B, 4, 32'h33DD_0000, 32'hD33D_0000};

    reset_n      = 1'b0;
    bus.start    = 1'b0;
    bus.mode     = 2'b01;
    bus.data_in  = 8'h00;
    bus.data_en  = 1'b0;
    bus.sym_tick = 1'b0;
    cyc();
    cyc();
    chk("rst.i", int'(bus.i_out), 0);
    chk("rst.q", int'(bus.q_out), 0);
    chk("rst.valid", int'(bus.sym_valid), 0);
    chk("rst.overflow", int'(bus.overflow), 0);
    chk("rst.underrun", int'(bus.underrun), 0);
    chk("rst.empty", int'(bus.fifo_empty), 1);
    reset_n   = 1'b1;
    bus.start = 1'b1;
    cyc();

    // Table: write one byte, check load latency, tick out every symbol.
    for (int r = 0; r < 5; r++) begin
      bus.mode = vec[r].mode;
      write_byte(vec[r].data);
      chk($sformatf("v%0d.empty_after_write", r), int'(bus.fifo_empty), 0);
      cyc();
      chk($sformatf("v%0d.empty_after_load", r), int'(bus.fifo_empty), 1);
      for (int j = 0; j < vec[r].nsym; j++) begin
        ni = vec[r].ei[31-4*j -: 4];
        nq = vec[r].eq[31-4*j -: 4];
        tick_chk($sformatf("v%0d.s%0d", r, j), int'($signed(ni)), int'($signed(nq)));
      end
      cyc();
      chk($sformatf("v%0d.pulse", r), int'(bus.sym_valid), 0);
      chk($sformatf("v%0d.hold_i", r), int'(bus.i_out), int'($signed(ni)));
    end

    // Overflow: 10 bytes, no ticks; 9 fit (shifter + 8 entries), the 10th drops.
    bus.mode = 2'b10;
    for (int n = 1; n <= 10; n++) begin
      write_byte(8'(n));
      if (n == 9) chk("ovf.before", int'(bus.overflow), 0);
    end
    chk("ovf.set", int'(bus.overflow), 1);
    for (int n = 1; n <= 9; n++) begin
      nb = 8'(n);
      tick_chk($sformatf("ovf.b%0d.s0", n), -3, -3);
      tick_chk($sformatf("ovf.b%0d.s1", n), gray_ref(nb[3:2]), gray_ref(nb[1:0]));
    end
    chk("ovf.drained", int'(bus.fifo_empty), 1);
    tick_underrun("ovf.underrun");
    cyc();
    chk("ovf.underrun_pulse", int'(bus.underrun), 0);
    chk("ovf.sticky", int'(bus.overflow), 1);

    // Abort via start after 2 of 4 QPSK symbols, with a byte still queued.
    bus.mode = 2'b01;
    write_byte(8'hB4);
    cyc();
    tick_chk("abort.s0", -3, 3);
    write_byte(8'h5A);
    tick_chk("abort.s1", -3, -3);
    bus.start = 1'b0;
    cyc();
    chk("abort.i", int'(bus.i_out), 0);
    chk("abort.q", int'(bus.q_out), 0);
    chk("abort.valid", int'(bus.sym_valid), 0);
    chk("abort.empty", int'(bus.fifo_empty), 1);
    chk("abort.overflow", int'(bus.overflow), 0);
    for (int t = 0; t < 3; t++) begin
      bus.sym_tick = 1'b1;
      cyc();
      bus.sym_tick = 1'b0;
      chk($sformatf("abort.t%0d.valid", t), int'(bus.sym_valid), 0);
      chk($sformatf("abort.t%0d.underrun", t), int'(bus.underrun), 0);
    end
    write_byte(8'h77);
    chk("abort.write_ignored", int'(bus.fifo_empty), 1);
    bus.start = 1'b1;
    cyc();
    chk("abort.restart_empty", int'(bus.fifo_empty), 1);

    // Mode switch mid-byte: current byte stays QPSK, next byte is 16QAM.
    bus.mode = 2'b01;
    write_byte(8'hB4);
    cyc();
    tick_chk("mode.s0", -3, 3);
    tick_chk("mode.s1", -3, -3);
    bus.mode = 2'b10;
    write_byte(8'h5A);
    tick_chk("mode.s2", 3, -3);
    tick_chk("mode.s3", 3, 3);
    tick_chk("mode.s4", -1, -1);
    tick_chk("mode.s5", 3, 3);
    tick_underrun("mode.end");

    // Asynchronous reset mid-byte.
    bus.mode = 2'b01;
    write_byte(8'hB4);
    write_byte(8'h5A);
    tick_chk("arst.s0", -3, 3);
    tick_chk("arst.s1", -3, -3);
    chk("arst.pre_empty", int'(bus.fifo_empty), 0);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst.i", int'(bus.i_out), 0);
    chk("arst.q", int'(bus.q_out), 0);
    chk("arst.valid", int'(bus.sym_valid), 0);
    chk("arst.empty", int'(bus.fifo_empty), 1);
    cyc();
    reset_n = 1'b1;
    cyc();
    tick_underrun("arst.after");
    chk("arst.empty_after", int'(bus.fifo_empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
